// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache types, geometry defaults and address-field helpers
// Used by both the icache and the dcache controllers.
package cache_pkg;

  typedef logic [31:0] word;

  localparam int LINE_SIZE = 4;
  localparam int OFFW      = $clog2(LINE_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } icache_state_t;

  // Byte-address bit positions of the word-offset, index and tag fields.
  function automatic int offset_lsb();
    return 2;
  endfunction

  function automatic int index_lsb(input int offw);
    return 2 + offw;
  endfunction

  function automatic int tag_lsb(input int offw, input int idxw);
    return 2 + offw + idxw;
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// rtl/icache_tag_array.sv - valid bits and tags with combinational lookup
// Valid bits reset and flush-clear in one cycle; tags are left unreset.
module icache_tag_array #(
  parameter int SETS  = 64,
  parameter int TAG_W = 22,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lookup_idx_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             hit_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             flush_i
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tags_q [SETS];

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tags_q[wr_idx_i] <= wr_tag_i;
    end
  end

  assign hit_o = valid_q[lookup_idx_i] && (tags_q[lookup_idx_i] == lookup_tag_i);

endmodule

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped blocking instruction cache controller
// Single-cycle hits, one outstanding line refill, whole-cache flush.
module icache_ctrl #(
  parameter int LINE_SIZE = 4,
  parameter int SETS      = 64,
  parameter int ADDR_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      fetch_addr,
  input  logic                   fetch_req,
  output logic                   fetch_ready,
  output logic                   fetch_valid,
  output logic [31:0]            fetch_data,
  output logic [ADDR_W-1:0]      fetch_resp_addr,
  input  logic                   flush,
  output logic [ADDR_W-1:0]      icache_req,
  output logic                   icache_requested,
  input  logic                   mem_full_icache,
  input  logic [ADDR_W-1:0]      icacheaddr,
  input  logic [LINE_SIZE*32-1:0] icachedata,
  input  logic                   icachevalid
);

  import cache_pkg::*;

  localparam int OFF_W   = $clog2(LINE_SIZE);
  localparam int IDX_W   = $clog2(SETS);
  localparam int OFF_LSB = offset_lsb();
  localparam int IDX_LSB = index_lsb(OFF_W);
  localparam int TAG_LSB = tag_lsb(OFF_W, IDX_W);
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_SIZE * 4 - 1);

  icache_state_t     state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [ADDR_W-1:0] line_req_q, line_req_d;
  word               fetch_data_q, fetch_data_d;
  logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
  logic              flush_pend_q, flush_pend_d;
  logic              install;

  logic [LINE_SIZE*32-1:0] data_q [SETS];
  logic [LINE_SIZE*32-1:0] rd_line;
  word                     rd_words  [LINE_SIZE];
  word                     ret_words [LINE_SIZE];

  logic [IDX_W-1:0] fetch_idx, miss_idx;
  logic [TAG_W-1:0] fetch_tag, miss_tag;
  logic [OFF_W-1:0] fetch_off, miss_off;
  logic             tag_hit;
  logic             line_match;

  assign fetch_idx = fetch_addr[IDX_LSB +: IDX_W];
  assign fetch_tag = fetch_addr[TAG_LSB +: TAG_W];
  assign fetch_off = fetch_addr[OFF_LSB +: OFF_W];
  assign miss_idx  = req_addr_q[IDX_LSB +: IDX_W];
  assign miss_tag  = req_addr_q[TAG_LSB +: TAG_W];
  assign miss_off  = req_addr_q[OFF_LSB +: OFF_W];

  // Only the line part of the returned address has to match the pending miss.
  assign line_match = ((icacheaddr ^ req_addr_q) & LINE_MASK) == '0;

  icache_tag_array #(
    .SETS  (SETS),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_tags (
    .clk          (clk),
    .rst          (rst),
    .lookup_idx_i (fetch_idx),
    .lookup_tag_i (fetch_tag),
    .hit_o        (tag_hit),
    .wr_en_i      (install),
    .wr_idx_i     (miss_idx),
    .wr_tag_i     (miss_tag),
    .flush_i      (flush)
  );

  always_ff @(posedge clk) begin
    if (install) begin
      data_q[miss_idx] <= icachedata;
    end
  end

  assign rd_line = data_q[fetch_idx];

  always_comb begin
    for (int i = 0; i < LINE_SIZE; i++) begin
      rd_words[i]  = rd_line[i*32 +: 32];
      ret_words[i] = icachedata[i*32 +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      line_req_q   <= '0;
      fetch_data_q <= '0;
      resp_addr_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      line_req_q   <= line_req_d;
      fetch_data_q <= fetch_data_d;
      resp_addr_q  <= resp_addr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    req_addr_d       = req_addr_q;
    line_req_d       = line_req_q;
    fetch_data_d     = fetch_data_q;
    resp_addr_d      = resp_addr_q;
    flush_pend_d     = flush_pend_q;
    install          = 1'b0;
    fetch_ready      = 1'b0;
    icache_requested = 1'b0;

    case (state_q)
      IDLE: begin
        fetch_ready = 1'b1;
        if (fetch_req) begin
          // A flush on the same edge wins over a hit on the old contents.
          if (tag_hit && !flush) begin
            fetch_data_d = rd_words[fetch_off];
            resp_addr_d  = fetch_addr & WORD_MASK;
            state_d      = RESP;
          end else begin
            req_addr_d = fetch_addr & WORD_MASK;
            line_req_d = fetch_addr & LINE_MASK;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (!mem_full_icache) begin
          icache_requested = 1'b1;
          state_d          = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          flush_pend_d = 1'b1;
        end
        if (icachevalid && line_match) begin
          install      = !flush && !flush_pend_q;
          fetch_data_d = ret_words[miss_off];
          resp_addr_d  = req_addr_q;
          flush_pend_d = 1'b0;
          state_d      = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fetch_valid     = (state_q == RESP);
  assign fetch_data      = fetch_data_q;
  assign fetch_resp_addr = resp_addr_q;
  assign icache_req      = line_req_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - self-checking bench for icache_ctrl
// Table of fetch vectors against a memory model, plus directed miss corner cases.
module tb_icache_ctrl;

  logic         clk;
  logic         rst;
  logic [31:0]  fetch_addr;
  logic         fetch_req;
  logic         fetch_ready;
  logic         fetch_valid;
  logic [31:0]  fetch_data;
  logic [31:0]  fetch_resp_addr;
  logic         flush;
  logic [31:0]  icache_req;
  logic         icache_requested;
  logic         mem_full_icache;
  logic [31:0]  icacheaddr;
  logic [127:0] icachedata;
  logic         icachevalid;

  int n_cmp;
  int n_fail;

  icache_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_addr       (fetch_addr),
    .fetch_req        (fetch_req),
    .fetch_ready      (fetch_ready),
    .fetch_valid      (fetch_valid),
    .fetch_data       (fetch_data),
    .fetch_resp_addr  (fetch_resp_addr),
    .flush            (flush),
    .icache_req       (icache_req),
    .icache_requested (icache_requested),
    .mem_full_icache  (mem_full_icache),
    .icacheaddr       (icacheaddr),
    .icachedata       (icachedata),
    .icachevalid      (icachevalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a * 32'h0001_0001) ^ 32'h0000_5A5A;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [31:0] la;
    la = a & ~32'hF;
    return {mem_word(la + 12), mem_word(la + 8), mem_word(la + 4), mem_word(la)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input logic [31:0] a, input bit fl, input bit exp_hit, input string tag);
    int          nreq;
    int          pend;
    int          lat;
    bit          got;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [31:0] rresp;
    nreq = 0; pend = -1; lat = -1; got = 0;
    raddr = '0; rdata = '0; rresp = '0;
    check({tag, "_ready_idle"}, {31'd0, fetch_ready}, 32'd1);
    fetch_addr = a; fetch_req = 1'b1; flush = fl;
    step();
    fetch_req = 1'b0; flush = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      icachevalid = 1'b0;
      if (fetch_valid) begin
        got = 1; lat = c; rdata = fetch_data; rresp = fetch_resp_addr;
        check({tag, "_ready_resp"}, {31'd0, fetch_ready}, 32'd0);
      end else begin
        if (icache_requested) begin
          nreq++; raddr = icache_req; pend = 2;
        end
        if (pend == 0) begin
          icachevalid = 1'b1; icacheaddr = raddr; icachedata = line_of(raddr);
        end
        if (pend >= 0) pend--;
        step();
      end
    end
    icachevalid = 1'b0;
    check({tag, "_got"}, {31'd0, got}, 32'd1);
    check({tag, "_nreq"}, nreq, exp_hit ? 32'd0 : 32'd1);
    check({tag, "_data"}, rdata, mem_word(a & ~32'h3));
    check({tag, "_resp_addr"}, rresp, a & ~32'h3);
    if (exp_hit) check({tag, "_hit_lat"}, lat, 32'd0);
    else         check({tag, "_req_addr"}, raddr, a & ~32'hF);
    step();
    check({tag, "_valid_drop"}, {31'd0, fetch_valid}, 32'd0);
  endtask

  task automatic manual_miss(input logic [31:0] a, input bit fl_wait, input bit fl_ret,
                             input bit bad_ret, input string tag);
    fetch_addr = a; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check({tag, "_req_pulse"}, {31'd0, icache_requested}, 32'd1);
    check({tag, "_req_addr"}, icache_req, a & ~32'hF);
    step();
    check({tag, "_req_once"}, {31'd0, icache_requested}, 32'd0);
    if (fl_wait) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
    if (bad_ret) begin
      icachevalid = 1'b1; icacheaddr = 32'h200; icachedata = line_of(32'h200);
      step();
      icachevalid = 1'b0;
      check({tag, "_bad_ignored"}, {31'd0, fetch_valid}, 32'd0);
      step();
      step();
      check({tag, "_still_wait_valid"}, {31'd0, fetch_valid}, 32'd0);
      check({tag, "_still_wait_ready"}, {31'd0, fetch_ready}, 32'd0);
    end
    icachevalid = 1'b1; icacheaddr = a; icachedata = line_of(a); flush = fl_ret;
    step();
    icachevalid = 1'b0; flush = 1'b0;
    check({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
    check({tag, "_data"}, fetch_data, mem_word(a & ~32'h3));
    check({tag, "_resp_addr"}, fetch_resp_addr, a & ~32'h3);
    step();
    check({tag, "_idle_ready"}, {31'd0, fetch_ready}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          fl;
    bit          hit;
  } vec_t;

  vec_t vecs [12];

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; fetch_addr = '0; fetch_req = 1'b0; flush = 1'b0;
    mem_full_icache = 1'b0; icacheaddr = '0; icachedata = '0; icachevalid = 1'b0;

    vecs[0]  = '{32'h100, 1'b0, 1'b0};
    vecs[1]  = '{32'h108, 1'b0, 1'b1};
    vecs[2]  = '{32'h10E, 1'b0, 1'b1};
    vecs[3]  = '{32'h500, 1'b0, 1'b0};
    vecs[4]  = '{32'h100, 1'b0, 1'b0};
    vecs[5]  = '{32'h104, 1'b0, 1'b1};
    vecs[6]  = '{32'h200, 1'b0, 1'b0};
    vecs[7]  = '{32'h108, 1'b0, 1'b1};
    vecs[8]  = '{32'h20C, 1'b0, 1'b1};
    vecs[9]  = '{32'h100, 1'b1, 1'b0};
    vecs[10] = '{32'h200, 1'b0, 1'b0};
    vecs[11] = '{32'h108, 1'b0, 1'b1};

    step();
    step();
    rst = 1'b0;
    check("rst_ready", {31'd0, fetch_ready}, 32'd1);
    check("rst_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_requested", {31'd0, icache_requested}, 32'd0);
    check("rst_data", fetch_data, 32'd0);
    check("rst_resp_addr", fetch_resp_addr, 32'd0);
    check("rst_icache_req", icache_req, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i].addr, vecs[i].fl, vecs[i].hit, $sformatf("v%0d", i));
    end

    // Memory full for three cycles after a miss on 0x300.
    mem_full_icache = 1'b1;
    fetch_addr = 32'h300; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("full%0d_requested", k), {31'd0, icache_requested}, 32'd0);
      check($sformatf("full%0d_ready", k), {31'd0, fetch_ready}, 32'd0);
      step();
    end
    mem_full_icache = 1'b0;
    #1;
    check("full_req_pulse", {31'd0, icache_requested}, 32'd1);
    check("full_req_addr", icache_req, 32'h300);
    step();
    check("full_req_once", {31'd0, icache_requested}, 32'd0);
    check("full_ready_wait", {31'd0, fetch_ready}, 32'd0);
    icachevalid = 1'b1; icacheaddr = 32'h300; icachedata = line_of(32'h300);
    step();
    icachevalid = 1'b0;
    check("full_valid", {31'd0, fetch_valid}, 32'd1);
    check("full_data", fetch_data, mem_word(32'h300));
    step();

    // Flush in IDLE turns a hitting line into a miss.
    flush = 1'b1;
    step();
    flush = 1'b0;
    run_vec(32'h108, 1'b0, 1'b0, "fl_idle_miss");
    run_vec(32'h108, 1'b0, 1'b1, "fl_idle_rehit");

    // Flush while waiting: word delivered, line not installed.
    flush = 1'b1;
    step();
    flush = 1'b0;
    manual_miss(32'h100, 1'b1, 1'b0, 1'b0, "fl_wait");
    run_vec(32'h100, 1'b0, 1'b0, "fl_wait_remiss");

    // Flush on the completing return also suppresses the install.
    flush = 1'b1;
    step();
    flush = 1'b0;
    manual_miss(32'h104, 1'b0, 1'b1, 1'b0, "fl_ret");
    run_vec(32'h100, 1'b0, 1'b0, "fl_ret_remiss");

    // Mismatched return is ignored; the correct one completes later.
    manual_miss(32'h400, 1'b0, 1'b0, 1'b1, "badret");
    run_vec(32'h404, 1'b0, 1'b1, "badret_hit");

    // Reset while waiting abandons the miss; late return is ignored.
    flush = 1'b1;
    step();
    flush = 1'b0;
    fetch_addr = 32'h100; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    icachevalid = 1'b1; icacheaddr = 32'h100; icachedata = line_of(32'h100);
    step();
    icachevalid = 1'b0;
    check("rstmid_valid", {31'd0, fetch_valid}, 32'd0);
    check("rstmid_ready", {31'd0, fetch_ready}, 32'd1);
    check("rstmid_requested", {31'd0, icache_requested}, 32'd0);
    check("rstmid_data", fetch_data, 32'd0);
    check("rstmid_resp_addr", fetch_resp_addr, 32'd0);
    check("rstmid_icache_req", icache_req, 32'd0);
    run_vec(32'h100, 1'b0, 1'b0, "rstmid_remiss");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped, blocking instruction cache between the fetch stage and main memory. It holds whole lines and answers a fetch hit in one cycle. On a miss it issues one line request on the main memory icache port. It then waits for the matching line, installs it and returns the requested word. It also supports a single-cycle whole-cache flush.

## Interface
- `LINE_SIZE`, default 4: 32-bit words per line. Must be a power of 2 and at least 2.
- `SETS`, default 64: number of lines. Must be a power of 2.
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `fetch_addr` in ADDR_W: byte address of the instruction. Bits [1:0] are ignored.
- `fetch_req` in 1: fetch request valid.
- `fetch_ready` out 1: the cache can accept a request this cycle.
- `fetch_valid` out 1: one-cycle response pulse.
- `fetch_data` out 32: instruction word.
- `fetch_resp_addr` out ADDR_W: address of the returned word, word-aligned.
- `flush` in 1: invalidate all lines.
- `icache_req` out ADDR_W: line-aligned miss address sent to main memory.
- `icache_requested` out 1: one-cycle request pulse to main memory.
- `mem_full_icache` in 1: main memory cannot accept a request.
- `icacheaddr` in ADDR_W: address of the returned line.
- `icachedata` in LINE_SIZE*32: returned line. Word 0 is in bits [31:0].
- `icachevalid` in 1: returned line is valid this cycle.

## Operation
Address fields:
- offset = addr[1+OFFW : 2], where OFFW = clog2(LINE_SIZE).
- index = the next clog2(SETS) bits above the offset.
- tag = the remaining upper bits.

States:
- **IDLE**
  - `fetch_ready` = 1.
  - When `fetch_req` is high, look up the index combinationally.
  - Hit (valid and tag equal): register the selected word and address, go to RESP.
  - Miss: latch the line-aligned address and the offset, go to REQ.
- **REQ**
  - `fetch_ready` = 0.
  - If `mem_full_icache` = 0: assert `icache_requested` for exactly this cycle, drive `icache_req`, go to WAIT.
  - Otherwise stay in REQ with `icache_requested` = 0.
- **WAIT**
  - Only a return with `icachevalid` = 1 and `icacheaddr` line-equal to the latched line address completes the miss. That return causes:
    - data[index] ← `icachedata`;
    - tag[index] ← latched tag;
    - valid[index] ← 1;
    - `fetch_data` ← word[offset];
    - go to RESP.
  - Returns with a mismatched address are ignored.
- **RESP**
  - `fetch_valid` = 1 for one cycle.
  - Back to IDLE.
  - `fetch_ready` = 0 in this state, so there is no back-to-back overlap.

Flush:
- `flush` clears every valid bit at the clock edge.
- Flush in IDLE: the request sampled in the same cycle is treated as a miss.
- Flush in WAIT: the miss still completes and the word is delivered, but the line is not installed (valid stays 0). A flush-pending flag records this and is cleared on leaving WAIT.
- A flush coinciding with the completing return also suppresses the install.

Reset:
- On reset: state = IDLE; all valid bits = 0; `fetch_valid`, `icache_requested`, `fetch_data`, `fetch_resp_addr`, `icache_req` = 0; flush-pending = 0.
- A reset during REQ or WAIT abandons the miss.
- A late memory return arriving in IDLE is ignored.
- The data and tag arrays are not reset.

## Timing
- Hit: accepted at edge N, `fetch_valid` high in cycle N+1, `fetch_ready` high again in N+2.
- Miss:
  - accepted at N;
  - `icache_requested` in N+1 at the earliest, delayed one cycle per cycle `mem_full_icache` is high;
  - return sampled at edge M;
  - `fetch_valid` in M+1.
- No backpressure on the response. The fetch stage must consume `fetch_valid` when it is high.
- At most one outstanding memory request at any time.

## Structure
- Package `cache_pkg` holds:
  - `word` typedef (logic [31:0]);
  - `LINE_SIZE` and the derived OFFW;
  - offset, index and tag range helpers;
  - `icache_state_t` enum {IDLE, REQ, WAIT, RESP}.
- The dcache reuses the same package.
- Sub-module `icache_tag_array` contains:
  - valid bits and tags;
  - combinational lookup (index, tag → hit);
  - write port (index, tag);
  - single-cycle flush-clear.
- Line data storage and the FSM stay in `icache_ctrl`.

## Test plan
- Cold miss:
  - Stimulus: fetch 0x100 with LINE_SIZE=4, SETS=64.
  - Required: `icache_req` = 0x100 with a one-cycle `icache_requested`. Memory then returns line {w3..w0} = {D,C,B,A}; `fetch_data` = A and `fetch_valid` one cycle later.
  - Then fetch 0x108: `fetch_data` = C at N+1, with no memory request.
- Conflict miss:
  - Stimulus: after the line above is installed, fetch 0x500 (same index, different tag).
  - Required: a new request to 0x500. A later fetch of 0x100 misses again.
- Memory full:
  - Stimulus: hold `mem_full_icache` = 1 for 3 cycles after a miss.
  - Required: `icache_requested` stays 0 for those 3 cycles, then pulses exactly once. `fetch_ready` = 0 throughout.
- Mismatched return:
  - Stimulus: while waiting on 0x100, present `icachevalid` with `icacheaddr` = 0x200.
  - Required: no response and state remains WAIT. A correct return 2 cycles later completes normally.
- Flush during WAIT:
  - Stimulus: assert `flush` while waiting on 0x100.
  - Required: the word is delivered. A repeat fetch of 0x100 misses.
  - Also: a flush in IDLE makes a previously hitting 0x108 miss.
- Reset mid-miss:
  - Stimulus: assert `rst` in WAIT, then present a return for 0x100.
  - Required: no `fetch_valid`, state IDLE, all outputs 0, and the next fetch of 0x100 misses.
